// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared framebuffer constants and capture FSM states
package vid_pkg;

  // Word address of line index 1023; identical to the display controller.
  localparam logic [17:0] FB_ORG = 18'h37FC0;

  localparam int ACT_W_DEF = 1024;
  localparam int ACT_H_DEF = 768;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VWAIT  = 3'd1,
    HWAIT  = 3'd2,
    ACTIVE = 3'd3,
    DRAIN  = 3'd4
  } cap_state_e;

  // Lines are stored bottom-up: line n lives at ORG + {~n, hword}, modulo 2^18.
  function automatic logic [17:0] fb_word_adr(input logic [17:0] org,
                                              input logic [9:0]  line,
                                              input logic [4:0]  hword);
    return org + {3'b000, ~line, hword};
  endfunction

endpackage

// File: rtl/vid_sync_edge.sv
// rtl/vid_sync_edge.sv - 2-FF synchronizer with history FF and edge detect
module vid_sync_edge #(
  parameter int EDGE = 0  // 0: synchronized level, 1: rising edge, 2: falling edge
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  // sh_q[1:0] is the synchronizer, sh_q[2] the history used for edge detection
  logic [2:0] sh_q;

  // shift the asynchronous input through the synchronizer and history flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sh_q <= 3'b000;
    else         sh_q <= {sh_q[1:0], d_i};
  end

  // select the level or the requested edge of the synchronized signal
  always_comb begin
    case (EDGE)
      1:       q_o = sh_q[1] & ~sh_q[2];
      2:       q_o = ~sh_q[1] & sh_q[2];
      default: q_o = sh_q[1];
    endcase
  end

endmodule

// File: rtl/vid_capture.sv
// rtl/vid_capture.sv - 1-bit video capture into the SRAM framebuffer
module vid_capture
  import vid_pkg::*;
#(
  parameter int          ACT_W   = ACT_W_DEF,
  parameter int          ACT_H   = ACT_H_DEF,
  parameter int          H_START = 160,
  parameter int          V_START = 3,
  parameter logic [17:0] ORG     = FB_ORG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cap_en,
  input  logic        inv,
  input  logic        pstb_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        pix_in,
  output logic        wreq,
  output logic [17:0] wadr,
  output logic [31:0] wdata,
  input  logic        wack,
  output logic        busy,
  output logic        frame_done,
  output logic        ovf
);

  logic stb_evt, pix_lvl, hs_evt, vs_evt, pix_val;

  vid_sync_edge #(.EDGE(1)) u_stb (.clk_i(clk), .rst_ni(rst), .d_i(pstb_in),  .q_o(stb_evt));
  vid_sync_edge #(.EDGE(0)) u_pix (.clk_i(clk), .rst_ni(rst), .d_i(pix_in),   .q_o(pix_lvl));
  vid_sync_edge #(.EDGE(1)) u_hs  (.clk_i(clk), .rst_ni(rst), .d_i(hsync_in), .q_o(hs_evt));
  vid_sync_edge #(.EDGE(2)) u_vs  (.clk_i(clk), .rst_ni(rst), .d_i(vsync_in), .q_o(vs_evt));

  assign pix_val = pix_lvl ^ inv;

  cap_state_e  state_q, state_d;
  logic [10:0] line_q, line_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] pix_q, pix_d;
  logic [31:0] sr_q, sr_d;
  logic        busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, ovf_clr;
  logic        push;
  logic [17:0] push_adr;
  logic [31:0] push_dat;

  logic [17:0] mem_adr_q [2];
  logic [31:0] mem_dat_q [2];
  logic        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]  fcnt_q, fcnt_d;
  logic        wreq_q, wreq_d;
  logic [17:0] wadr_q, wadr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        pop, push_ok, drop;

  // frame/line sequencing and pixel packing; vsync beats hsync beats strobe
  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    cnt_d    = cnt_q;
    pix_d    = pix_q;
    sr_d     = sr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    ovf_clr  = 1'b0;
    push     = 1'b0;
    push_adr = fb_word_adr(ORG, line_q[9:0], pix_q[9:5]);
    push_dat = {pix_val, sr_q[31:1]};
    case (state_q)
      IDLE: begin
        if (vs_evt && cap_en) begin
          state_d = VWAIT;
          busy_d  = 1'b1;
          ovf_clr = 1'b1;
          line_d  = '0;
          cnt_d   = '0;
        end
      end
      VWAIT: begin
        if (vs_evt) state_d = DRAIN;
        else if (hs_evt) begin
          if (cnt_q == 16'(V_START - 1)) begin
            state_d = HWAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      HWAIT: begin
        if (vs_evt) state_d = DRAIN;
        else if (hs_evt) cnt_d = '0;
        else if (stb_evt) begin
          if (cnt_q == 16'(H_START)) begin
            state_d = ACTIVE;
            pix_d   = 11'd1;
            sr_d    = push_dat;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      ACTIVE: begin
        if (vs_evt) state_d = DRAIN;
        else if (hs_evt) begin
          cnt_d   = '0;
          pix_d   = '0;
          state_d = HWAIT;
          // a short line still counts as a line; a full one was counted already
          if (pix_q < 11'(ACT_W)) begin
            line_d = line_q + 11'd1;
            if (line_q + 11'd1 == 11'(ACT_H)) state_d = DRAIN;
          end
        end else if (stb_evt && (pix_q < 11'(ACT_W))) begin
          sr_d  = push_dat;
          pix_d = pix_q + 11'd1;
          push  = (pix_q[4:0] == 5'd31);
          if (pix_q == 11'(ACT_W - 1)) begin
            line_d = line_q + 11'd1;
            if (line_q + 11'd1 == 11'(ACT_H)) state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((fcnt_q == 2'd0) && !wreq_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // two-entry write FIFO; the registered outputs always show the next head
  always_comb begin
    pop      = wreq_q & wack;
    push_ok  = push & ((fcnt_q != 2'd2) | pop);
    drop     = push & ~push_ok;
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    fcnt_d   = fcnt_q + {1'b0, push_ok} - {1'b0, pop};
    ovf_d    = ovf_clr ? 1'b0 : (ovf_q | drop);
    wreq_d   = (fcnt_d != 2'd0);
    wadr_d   = wadr_q;
    wdata_d  = wdata_q;
    if (fcnt_d != 2'd0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
        wadr_d  = push_adr;
        wdata_d = push_dat;
      end else begin
        wadr_d  = mem_adr_q[rd_ptr_d];
        wdata_d = mem_dat_q[rd_ptr_d];
      end
    end
  end

  // state, counters, FIFO storage and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      line_q       <= '0;
      cnt_q        <= '0;
      pix_q        <= '0;
      sr_q         <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
      mem_adr_q[0] <= '0;
      mem_adr_q[1] <= '0;
      mem_dat_q[0] <= '0;
      mem_dat_q[1] <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      fcnt_q       <= '0;
      wreq_q       <= 1'b0;
      wadr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      cnt_q    <= cnt_d;
      pix_q    <= pix_d;
      sr_q     <= sr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      wreq_q   <= wreq_d;
      wadr_q   <= wadr_d;
      wdata_q  <= wdata_d;
      if (push_ok) begin
        mem_adr_q[wr_ptr_q] <= push_adr;
        mem_dat_q[wr_ptr_q] <= push_dat;
      end
    end
  end

  assign wreq       = wreq_q;
  assign wadr       = wadr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign ovf        = ovf_q;

endmodule
